// File: rtl/reg_dump.sv
// Register-file dump streamer: reads 2**pw registers one at a time and sends each as a
// valid/ready beat. Optional macro DUMP_FLAGS_EN appends a final beat carrying the flag snapshot.
module reg_dump #(
  parameter int pw = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [pw:0]   rd_addr,
  input  logic [7:0]    dat_in,
  input  logic          zeroIn,
  input  logic          ngtvIn,
  input  logic          scryIn,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam logic [pw:0] last_addr = {1'b0, {pw{1'b1}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    FLAG = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [pw:0] rd_addr_r, rd_addr_s;
  logic [7:0]  out_data_r, out_data_s;
  logic        out_valid_r, out_valid_s;
  logic        out_last_r, out_last_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;

`ifdef DUMP_FLAGS_EN
  logic [2:0]  flags_r, flags_s;
`else
  logic        unused_flags_s;
  assign unused_flags_s = ^{zeroIn, ngtvIn, scryIn};
`endif

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_s     = state_r;
    rd_addr_s   = rd_addr_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    out_last_s  = out_last_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
`ifdef DUMP_FLAGS_EN
    flags_s     = flags_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = READ;
          rd_addr_s = '0;
          busy_s    = 1'b1;
`ifdef DUMP_FLAGS_EN
          flags_s   = {scryIn, ngtvIn, zeroIn};
`endif
        end else begin
          busy_s = 1'b0;
        end
      end
      READ: begin
        // dat_in is sampled live here so late writes to unread registers are seen
        state_s     = SEND;
        out_data_s  = dat_in;
        out_valid_s = 1'b1;
`ifdef DUMP_FLAGS_EN
        out_last_s  = 1'b0;
`else
        out_last_s  = (rd_addr_r == last_addr);
`endif
      end
      SEND: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
          if (rd_addr_r == last_addr) begin
`ifdef DUMP_FLAGS_EN
            state_s     = FLAG;
            out_valid_s = 1'b1;
            out_last_s  = 1'b1;
            out_data_s  = {5'b00000, flags_r};
`else
            state_s     = DONE;
            done_s      = 1'b1;
`endif
          end else begin
            state_s   = READ;
            rd_addr_s = rd_addr_r + {{pw{1'b0}}, 1'b1};
          end
        end else begin
          state_s = SEND;
        end
      end
      FLAG: begin
        if (out_ready) begin
          state_s     = DONE;
          done_s      = 1'b1;
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
        end else begin
          state_s = FLAG;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      rd_addr_r   <= '0;
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef DUMP_FLAGS_EN
      flags_r     <= 3'b000;
`endif
    end else begin
      state_r     <= state_s;
      rd_addr_r   <= rd_addr_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
`ifdef DUMP_FLAGS_EN
      flags_r     <= flags_s;
`endif
    end
  end

  assign rd_addr   = rd_addr_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_reg_dump.sv
// Directed self-checking bench for reg_dump (pw=3): plain dump, stall, ignored restarts,
// mid-dump reset and a live register write. Adapts to DUMP_FLAGS_EN when defined.
module tb_reg_dump;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] rd_addr;
  logic [7:0] dat_in;
  logic       zeroIn, ngtvIn, scryIn;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [7:0] regs [8];
  int         checks = 0;
  int         errors = 0;

`ifdef DUMP_FLAGS_EN
  localparam int nbeats = 9;
`else
  localparam int nbeats = 8;
`endif

  reg_dump #(.pw(3)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr), .dat_in(dat_in),
    .zeroIn(zeroIn), .ngtvIn(ngtvIn), .scryIn(scryIn), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  assign dat_in = regs[rd_addr[2:0]];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // One full dump. stall_beat>=0 holds out_ready low 5 cycles on that beat.
  task automatic dump(input int stall_beat, input bit repulse, input bit write6);
    int         beat = 0;
    int         cyc = 0;
    int         stall = 0;
    bit         done_seen = 1'b0;
    logic [7:0] exp_d;
    for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i);
    zeroIn = 1'b1; ngtvIn = 1'b0; scryIn = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    zeroIn = 1'b0; ngtvIn = 1'b1; scryIn = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_novalid", 32'(out_valid), 32'd0);
    for (int c = 0; c < 200 && !done_seen; c++) begin
      tick();
      cyc++;
      start = 1'b0;
      if (done) begin
        done_seen = 1'b1;
        check("done_beats", 32'(beat), 32'(nbeats));
        check("done_busy", 32'(busy), 32'd1);
        check("done_novalid", 32'(out_valid), 32'd0);
`ifndef DUMP_FLAGS_EN
        if (stall_beat < 0) check("done_cycle", 32'(cyc), 32'd16);
`endif
      end else if (out_valid) begin
        if (beat < 8) exp_d = (write6 && beat == 6) ? 8'hAA : 8'h10 + 8'(beat);
        else exp_d = 8'h05;
        check("beat_data", 32'(out_data), 32'(exp_d));
        check("beat_last", 32'(out_last), 32'(beat == nbeats - 1));
        check("beat_addr", 32'(rd_addr), 32'(beat < 8 ? beat : 7));
        if (beat == stall_beat && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
          if (stall_beat < 0 && beat < 8) check("beat_spacing", 32'(cyc), 32'(2 * beat + 1));
          if (repulse && (beat == 2 || beat == 6)) start = 1'b1;
          if (write6 && beat == 2) regs[6] = 8'hAA;
          beat++;
        end
      end
    end
    check("done_seen", 32'(done_seen), 32'd1);
    if (stall_beat >= 0) check("stall_len", 32'(stall), 32'd5);
    if (repulse) start = 1'b1;
    tick();
    start = 1'b0;
    check("post_idle_busy", 32'(busy), 32'd0);
    check("post_idle_done", 32'(done), 32'd0);
    repeat (3) begin
      tick();
      check("stay_idle_busy", 32'(busy), 32'd0);
      check("stay_idle_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    bit found = 1'b0;
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    zeroIn = 1'b1; ngtvIn = 1'b1; scryIn = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i);
    repeat (2) tick();
    check_idle_zero("reset");
    reset = 1'b0;
    tick();

    dump(-1, 1'b0, 1'b0);
    dump(3, 1'b0, 1'b0);
    dump(-1, 1'b1, 1'b0);

    // Reset while register 4 is being offered: dump is abandoned with no done pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (out_valid && rd_addr == 4'd4) found = 1'b1;
    end
    check("rst_reach_reg4", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_zero("midreset");
    repeat (3) begin
      tick();
      check("midreset_nodone", 32'(done), 32'd0);
      check("midreset_idle", 32'(busy), 32'd0);
    end

    dump(-1, 1'b0, 1'b0);
    dump(-1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
